// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, reads a synchronous ROM and buffers bytes in a 2-entry queue.
// Jumps redirect the PC and flush the queue. FETCH_HALT_EN enables stop-on-HALT_OPCODE.
module fetch_unit #(
    parameter int                 ADDR_W      = 16,
    parameter int                 INSTR_W     = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               jmp_valid,
    input  logic [ADDR_W-1:0]  jmp_addr,
    output logic               halted
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [INSTR_W-1:0]  q_instr_r [2];
    logic [ADDR_W-1:0]   q_pc_r [2];
    logic [1:0]          count_r;
    logic                inflight_r;
    logic [ADDR_W-1:0]   inflight_pc_r;
    logic                pop_s;
    logic                push_s;
    logic                issue_s;
    logic                halt_hit_s;
    logic [2:0]          credit_used_s;

    // Queue head drives the datapath interface directly from registers.
    assign instr_valid = (count_r != 2'd0);
    assign instr       = q_instr_r[0];
    assign instr_pc    = q_pc_r[0];
    assign halted      = (state_r == ST_HALT);
    assign pop_s       = instr_valid & instr_ready;

`ifdef FETCH_HALT_EN
    assign halt_hit_s = push_s && (rom_data == HALT_OPCODE);
`else
    assign halt_hit_s = 1'b0;
`endif

    // Fetch issue, jump bypass and capture qualification.
    always_comb begin
        credit_used_s = {1'b0, count_r} + {2'b00, inflight_r};
        issue_s       = 1'b0;
        if (rst_n && (state_r == ST_RUN) && ((credit_used_s < 3'd2) || pop_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        rom_en   = rst_n & (jmp_valid | issue_s);
        if (jmp_valid) begin
            rom_addr = jmp_addr;
        end else begin
            rom_addr = pc_r;
        end
        // Returning data is dropped on a jump (stale) and while halted.
        push_s = inflight_r && !jmp_valid && (state_r == ST_RUN);
    end

    // Run/halt next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_hit_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (jmp_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Program counter and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else begin
            inflight_r    <= rom_en;
            inflight_pc_r <= rom_addr;
            if (jmp_valid) begin
                pc_r <= jmp_addr + PC_STEP;
            end else if (issue_s) begin
                pc_r <= pc_r + PC_STEP;
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    // Two-entry shifting queue; entry 0 is always the head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r      <= 2'd0;
            q_instr_r[0] <= '0;
            q_instr_r[1] <= '0;
            q_pc_r[0]    <= '0;
            q_pc_r[1]    <= '0;
        end else if (jmp_valid) begin
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        q_instr_r[0] <= rom_data;
                        q_pc_r[0]    <= inflight_pc_r;
                    end else begin
                        q_instr_r[1] <= rom_data;
                        q_pc_r[1]    <= inflight_pc_r;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    q_instr_r[0] <= q_instr_r[1];
                    q_pc_r[0]    <= q_pc_r[1];
                    count_r      <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        q_instr_r[0] <= rom_data;
                        q_pc_r[0]    <= inflight_pc_r;
                    end else begin
                        q_instr_r[0] <= q_instr_r[1];
                        q_pc_r[0]    <= q_pc_r[1];
                        q_instr_r[1] <= rom_data;
                        q_pc_r[1]    <= inflight_pc_r;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: ROM model plus an in-order scoreboard of expected {instr, pc}.
module tb_fetch_unit;

    localparam logic [15:0] TB_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [7:0]  instr;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr;
    logic [15:0] instr_pc;
    logic        jmp_valid;
    logic [15:0] jmp_addr;
    logic        halted;

    logic        halt_at_3;
    exp_t        exp_q [$];
    int          total_cnt = 0;
    int          bad_cnt   = 0;
    int          deliv_cnt = 0;

    fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .jmp_valid   (jmp_valid),
        .jmp_addr    (jmp_addr),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Linear ROM; 0xFF only where a halt is wanted so other tests never stop by accident.
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        logic [7:0] b;
        b = a[7:0];
        if (halt_at_3 && (a == 16'h0003)) return 8'hFF;
        else if (b == 8'hFF) return 8'h7F;
        else return b;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [15:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 16'(i);
            e.instr = rom_byte(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // Synchronous-read ROM.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_byte(rom_addr);
    end

    // Scoreboard: compare every transfer, restart expected stream on reset or jump.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            push_seq(TB_RESET_PC, 40);
            deliv_cnt <= 0;
        end else begin
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_val("sb_instr", {24'd0, instr}, {24'd0, exp_q[0].instr});
                    check_val("sb_pc", {16'd0, instr_pc}, {16'd0, exp_q[0].pc});
                    void'(exp_q.pop_front());
                end
                deliv_cnt <= deliv_cnt + 1;
            end
            if (jmp_valid) begin
                exp_q.delete();
                push_seq(jmp_addr, 40);
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_edge();
        drive_edge();
        check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_val("rst_rom_en", {31'd0, rom_en}, 32'd0);
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        check_val("rst_instr", {24'd0, instr}, 32'd0);
        check_val("rst_pc", {16'd0, instr_pc}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic do_jump(input logic [15:0] target, input string tag);
        drive_edge();
        jmp_valid = 1'b1;
        jmp_addr  = target;
        @(negedge clk);
        check_val({tag, "_rom_en"}, {31'd0, rom_en}, 32'd1);
        check_val({tag, "_rom_addr"}, {16'd0, rom_addr}, {16'd0, target});
        drive_edge();
        jmp_valid   = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        check_val({tag, "_j1_valid"}, {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check_val({tag, "_j2_valid"}, {31'd0, instr_valid}, 32'd1);
        check_val({tag, "_j2_pc"}, {16'd0, instr_pc}, {16'd0, target});
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        jmp_valid   = 1'b0;
        jmp_addr    = 16'h0000;
        halt_at_3   = 1'b0;

        // Test 1: first fetch and streaming.
        do_reset();
        @(negedge clk);
        check_val("t1_c0_rom_en", {31'd0, rom_en}, 32'd1);
        check_val("t1_c0_addr", {16'd0, rom_addr}, {16'd0, TB_RESET_PC});
        check_val("t1_c0_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check_val("t1_c1_valid", {31'd0, instr_valid}, 32'd0);
        check_val("t1_c1_addr", {16'd0, rom_addr}, 32'd1);
        @(negedge clk);
        check_val("t1_c2_valid", {31'd0, instr_valid}, 32'd1);
        check_val("t1_c2_instr", {24'd0, instr}, 32'd0);
        @(negedge clk);
        check_val("t1_c3_instr", {24'd0, instr}, 32'd1);
        check_val("t1_c3_pc", {16'd0, instr_pc}, 32'd1);
        repeat (4) @(negedge clk);

        // Test 2: backpressure; head held, fetch stops once credit is used up.
        drive_edge();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t2_valid", {31'd0, instr_valid}, 32'd1);
            check_val("t2_instr", {24'd0, instr}, {24'd0, exp_q[0].instr});
            check_val("t2_pc", {16'd0, instr_pc}, {16'd0, exp_q[0].pc});
            check_val("t2_rom_en", {31'd0, rom_en}, 32'd0);
        end
        drive_edge();
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Test 3: jump while the queue is full.
        drive_edge();
        instr_ready = 1'b0;
        repeat (3) drive_edge();
        do_jump(16'h0100, "t3");
        repeat (5) @(negedge clk);

        // Test 4: jump in the same cycle as a transfer.
        drive_edge();
        jmp_valid = 1'b1;
        jmp_addr  = 16'h0200;
        @(negedge clk);
        check_val("t4_xfer_valid", {31'd0, instr_valid}, 32'd1);
        drive_edge();
        jmp_valid = 1'b0;
        @(negedge clk);
        check_val("t4_j1_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check_val("t4_j2_pc", {16'd0, instr_pc}, 32'h0200);
        repeat (4) @(negedge clk);

        // Test 5: PC wrap.
        do_jump(16'hFFFF, "t5");
        @(negedge clk);
        check_val("t5_wrap_pc", {16'd0, instr_pc}, 32'h0000);
        repeat (3) @(negedge clk);

        // Test 6: halt opcode at address 3.
        halt_at_3 = 1'b1;
        do_reset();
        repeat (12) @(negedge clk);
`ifdef FETCH_HALT_EN
        check_val("t6_deliv", 32'(deliv_cnt), 32'd4);
        check_val("t6_halted", {31'd0, halted}, 32'd1);
        check_val("t6_rom_en", {31'd0, rom_en}, 32'd0);
        check_val("t6_valid", {31'd0, instr_valid}, 32'd0);
        drive_edge();
        jmp_valid = 1'b1;
        jmp_addr  = 16'h0010;
        @(negedge clk);
        check_val("t6_j_rom_en", {31'd0, rom_en}, 32'd1);
        drive_edge();
        jmp_valid = 1'b0;
        @(negedge clk);
        check_val("t6_unhalted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        check_val("t6_resume_pc", {16'd0, instr_pc}, 32'h0010);
        repeat (3) @(negedge clk);
`else
        check_val("t6_halted", {31'd0, halted}, 32'd0);
        check_val("t6_stream", {31'd0, (deliv_cnt > 4)}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
